// File: rtl/pack_u32_stream.sv
// Streaming LEB128 encoder: one W-bit value in, its LEB128 byte sequence out, one byte per cycle.
// Define LEB128_SIGNED_EN for signed (SLEB128) encoding of two's-complement input.
module pack_u32_stream #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         i_ready,
  output logic [7:0]   o_byte,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         o_last,
  output logic [2:0]   o_idx,
  output logic [2:0]   o_len
);

  localparam int unsigned MAXLEN = (W + 6) / 7;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t       r_state;
  logic [W-1:0] r_sh;
  logic [7:0]   r_byte;
  logic         r_valid;
  logic         r_last;
  logic [2:0]   r_idx;
  logic [2:0]   r_len;

  logic         w_in_fire;
  logic         w_out_fire;
  logic [2:0]   w_load_len;
  logic [W-1:0] w_sh_next;
  logic [2:0]   w_idx_next;
  logic         w_last_next;

  // Index of the last byte that must be emitted for value d.
  function automatic logic [2:0] calc_len(input logic [W-1:0] d);
    logic [2:0] len;
`ifdef LEB128_SIGNED_EN
    logic signed [W-1:0] rem;
    logic signed [W-1:0] hi;
    len = 3'(MAXLEN - 1);
    for (int k = int'(MAXLEN) - 1; k >= 0; k--) begin
      rem = $signed(d) >>> (7 * k);
      hi  = rem >>> 6;
      if (hi == '0 || hi == '1) len = 3'(k);
    end
`else
    logic [W-1:0] rem;
    len = 3'd0;
    for (int k = 0; k < int'(MAXLEN); k++) begin
      rem = d >> (7 * k);
      if (rem != '0) len = 3'(k);
    end
`endif
    return len;
  endfunction

  // Arithmetic shift keeps the sign in the unused bits of the top signed byte.
`ifdef LEB128_SIGNED_EN
  assign w_sh_next = W'($signed(r_sh) >>> 7);
`else
  assign w_sh_next = r_sh >> 7;
`endif

  assign w_load_len  = calc_len(i_data);
  assign w_idx_next  = r_idx + 3'd1;
  assign w_last_next = (w_idx_next == r_len);

  // Combinational o_ready->i_ready lets a new value follow the last byte with no bubble.
  assign i_ready    = (r_state == S_IDLE) | (r_valid & o_ready & r_last);
  assign w_in_fire  = i_valid & i_ready;
  assign w_out_fire = r_valid & o_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_byte  <= 8'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_idx   <= 3'd0;
      r_len   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            r_state <= S_EMIT;
            r_sh    <= i_data;
            r_byte  <= {(w_load_len != 3'd0), i_data[6:0]};
            r_valid <= 1'b1;
            r_last  <= (w_load_len == 3'd0);
            r_idx   <= 3'd0;
            r_len   <= w_load_len;
          end
        end
        S_EMIT: begin
          if (w_in_fire) begin
            r_state <= S_EMIT;
            r_sh    <= i_data;
            r_byte  <= {(w_load_len != 3'd0), i_data[6:0]};
            r_valid <= 1'b1;
            r_last  <= (w_load_len == 3'd0);
            r_idx   <= 3'd0;
            r_len   <= w_load_len;
          end else if (w_out_fire) begin
            if (r_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
            end else begin
              r_sh   <= w_sh_next;
              r_byte <= {~w_last_next, w_sh_next[6:0]};
              r_last <= w_last_next;
              r_idx  <= w_idx_next;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte  = r_byte;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_idx   = r_idx;
  assign o_len   = r_len;

endmodule

// File: tb/tb_pack_u32_stream.sv
// Scoreboard bench for pack_u32_stream: expected LEB128 bytes are queued on input transfer
// and checked every cycle against the presented byte, popped on output transfer.
module tb_pack_u32_stream;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic [2:0] idx;
    logic [2:0] len;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] i_data;
  logic         i_valid;
  logic         i_ready;
  logic [7:0]   o_byte;
  logic         o_valid;
  logic         o_ready;
  logic         o_last;
  logic [2:0]   o_idx;
  logic [2:0]   o_len;

  exp_t q[$];
  int   n_vec;
  int   n_err;
  bit   fired;

  pack_u32_stream #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .o_byte(o_byte), .o_valid(o_valid), .o_ready(o_ready),
    .o_last(o_last), .o_idx(o_idx), .o_len(o_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference LEB128 encoder (standard byte-at-a-time formulation).
  task automatic push_exp(input logic [W-1:0] v);
    logic [7:0] bytes[$];
    logic [W-1:0] x;
    logic [7:0] c;
    bit more;
    x = v;
    more = 1'b1;
    while (more) begin
      c = {1'b0, x[6:0]};
`ifdef LEB128_SIGNED_EN
      x = W'($signed(x) >>> 7);
      more = !(((x == '0) && !c[6]) || ((x == '1) && c[6]));
`else
      x = x >> 7;
      more = (x != '0);
`endif
      if (more) c[7] = 1'b1;
      bytes.push_back(c);
    end
    for (int i = 0; i < bytes.size(); i++)
      q.push_back('{b: bytes[i], last: (i == bytes.size() - 1),
                    idx: 3'(i), len: 3'(bytes.size() - 1)});
  endtask

  // One clock: check outputs mid-cycle, update scoreboard, advance past the edge.
  task automatic cyc();
    @(negedge clk);
    chk("o_valid", 32'(o_valid), 32'(q.size() != 0));
    chk("i_ready", 32'(i_ready), 32'((q.size() == 0) || (o_ready && q.size() == 1)));
    if (q.size() != 0 && o_valid) begin
      chk("o_byte", 32'(o_byte), 32'(q[0].b));
      chk("o_last", 32'(o_last), 32'(q[0].last));
      chk("o_idx",  32'(o_idx),  32'(q[0].idx));
      chk("o_len",  32'(o_len),  32'(q[0].len));
    end
    fired = i_valid && i_ready;
    if (o_valid && o_ready && q.size() != 0) void'(q.pop_front());
    if (fired) push_exp(i_data);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v);
    int n;
    i_data  = v;
    i_valid = 1'b1;
    n = 0;
    fired = 1'b0;
    while (!fired && n < 50) begin
      cyc();
      n++;
    end
    chk("send_timeout", 32'(fired), 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    chk("drain_timeout", q.size(), 32'd0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    i_data  = '0;
    i_valid = 1'b0;
    o_ready = 1'b1;
    #12;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_byte",  32'(o_byte),  32'd0);
    chk("rst_o_last",  32'(o_last),  32'd0);
    chk("rst_o_idx",   32'(o_idx),   32'd0);
    chk("rst_o_len",   32'(o_len),   32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero encodes to a single 0x00 presented the cycle after acceptance.
    send(32'd0);
    chk("zero_latency_valid", 32'(o_valid), 32'd1);
    chk("zero_byte", 32'(o_byte), 32'h00);
    drain();

    send(32'd624485);
    drain();

    // All-ones followed immediately by 127: second value must follow with no bubble.
    send(32'hFFFF_FFFF);
    send(32'd127);
    chk("b2b_byte", 32'(o_byte), 32'h7F);
    drain();

    // Stall pattern: 0x80 must hold while o_ready is low.
    o_ready = 1'b0;
    send(32'd128);
    for (int i = 0; i < 8; i++) begin
      o_ready = ~o_ready;
      cyc();
    end
    o_ready = 1'b1;
    drain();

    // Asynchronous reset after byte 0 of a multi-byte value.
    send(32'hFFFF_FFFF);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_o_valid", 32'(o_valid), 32'd0);
    chk("midrst_i_ready", 32'(i_ready), 32'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_i_ready", 32'(i_ready), 32'd1);
    send(32'd5);
    drain();

`ifdef LEB128_SIGNED_EN
    send(32'hFFFF_FF80);
    drain();
    send(32'd64);
    drain();
    send(32'hFFFF_FFFF);
    drain();
`endif

    // Random values with random downstream back-pressure.
    for (int i = 0; i < 40; i++) begin
      i_data  = $urandom() >> $urandom_range(31, 0);
      i_valid = ($urandom_range(3, 0) != 0);
      o_ready = ($urandom_range(3, 0) != 0);
      cyc();
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    drain();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
